hspi_host_link: RTL and testbench
=================================

# hspi_host_link

Host-side endpoint of the 16-bit half-duplex HSPI pad link exported by the Rift2 user-project wrapper. It sits directly across the pins from the core:
- It consumes words the core drives (core `tx_enable` with data), buffering them in an RX FIFO for host logic.
- It drives words into the core's receive path (`rx_enable` with data).
- It arbitrates bus direction with turnaround gaps and a burst cap, so the core is never locked out.

## Interface
Parameters:
- `DW`, 16: data width of the HSPI bus and of both stream ports.
- `FIFO_DEPTH`, 8: RX FIFO entries; power of two, at least 2.
- `TURN_CYC`, 2: idle cycles inserted before the host drives the bus; range 1..7.
- `MAX_BURST`, 16: maximum host words per drive window; range 1..255.

Ports:
- `clock`  in  1: the forwarded HSPI clock from the core (core `io_out[26]`); the only clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `hspi_tx_enable_i`  in  1: core drives valid data on the bus this cycle.
- `hspi_data_i`  in  DW: bus value sampled from the pads.
- `hspi_data_o`  out  DW: bus value driven by the host.
- `hspi_data_oe`  out  1: 1 = host drives the pads.
- `hspi_rx_enable_o`  out  1: host word valid to the core.
- `dn_valid`, `dn_data`  in  1, DW: host-to-core stream.
- `dn_ready`  out  1: `dn_data` is accepted this cycle.
- `up_valid`, `up_data`  out  1, DW: core-to-host stream, taken from the FIFO head.
- `up_ready`  in  1: host consumes the FIFO head.
- `clr_status`  in  1: clears the sticky flags.
- `rx_overflow`  out  1: sticky; a core word was dropped because the FIFO was full.
- `collision`  out  1: sticky; the core asserted `tx_enable` while the host was driving.

## Operation
- FSM states: IDLE, TURN, DRIVE, RELEASE. Reset enters IDLE.
- **IDLE**
  - `oe` = 0.
  - If `hspi_tx_enable_i` = 1, `hspi_data_i` is pushed into the FIFO.
  - If `dn_valid` = 1 and `hspi_tx_enable_i` = 0, go to TURN and load the turn counter with `TURN_CYC`.
- **TURN**
  - `oe` = 0; the counter decrements each cycle.
  - If `hspi_tx_enable_i` = 1, capture the word and return to IDLE (core has priority).
  - When the counter reaches 1 with no core activity, go to DRIVE and zero the burst counter.
- **DRIVE**
  - `oe` = 1.
  - `dn_ready` = (burst count < `MAX_BURST`) and `hspi_tx_enable_i` = 0.
  - Each accept registers `dn_data` onto `hspi_data_o` with `hspi_rx_enable_o` = 1 the next cycle, and increments the burst count.
  - A cycle with no accept drives `hspi_rx_enable_o` = 0 and holds the last data.
  - Go to RELEASE when either `dn_valid` = 0 or the burst count reaches `MAX_BURST`.
- **RELEASE**
  - Lasts one cycle: `oe` = 0, `rx_enable` = 0, `dn_ready` = 0.
  - Next state is IDLE.
  - Because `TURN` is only re-entered through IDLE, every host window after a cap is preceded by at least one full IDLE cycle.
- **Collision**: `hspi_tx_enable_i` = 1 while in DRIVE.
  - Same cycle: `dn_ready` = 0.
  - Next cycle: `oe` = 0 and `rx_enable` = 0, `collision` is set, and the FSM goes to IDLE.
  - The colliding word is not captured. The last accepted dn word has already been driven, so it is not lost.
- **FIFO**
  - Push and pop in the same cycle are both allowed, including when full; a pop frees the slot for that cycle's push.
  - A push when full and not popping drops the word and sets `rx_overflow`.
  - Pointers are `log2(FIFO_DEPTH)+1` bits wide and wrap naturally.
  - `up_valid` = not empty; `up_data` = head entry.
- **Status flags**
  - `clr_status` clears both flags.
  - A set event in the same cycle as `clr_status` wins, so the flag stays 1.

## Timing
- Reset: every output is 0; the FIFO is empty and the FSM is in IDLE.
- RX latency: a word sampled with `tx_enable` at edge N gives `up_valid` = 1 after edge N if the FIFO was empty.
- TX latency: a `dn` accept at edge N puts the word on the pads, with `rx_enable` = 1, after edge N.
- Turnaround:
  - From `dn_valid` rising in IDLE, the first `dn_ready` comes `TURN_CYC` + 1 cycles later.
  - `oe` falls exactly one cycle after the last accepted word's drive cycle.
- `hspi_data_o`, `hspi_data_oe`, and `hspi_rx_enable_o` are all flop outputs; there is no combinational path from inputs to pads.
- Reset asserted mid-burst: `oe`, `rx_enable`, and all data outputs drop asynchronously, and the FIFO contents are discarded.

## Test plan
- **Reset values**: assert `reset_n` = 0 mid-DRIVE -> `oe`, `rx_enable`, `dn_ready`, `up_valid`, and both flags read 0 immediately.
- **RX ordering**: core sends 0x1234, 0xABCD, 0x0001 on consecutive cycles with `up_ready` = 1 -> `up_data` shows the same sequence, one cycle late each.
- **Overflow**: `up_ready` = 0, core sends 9 words with `FIFO_DEPTH` = 8 -> 8 stored, the 9th dropped, `rx_overflow` = 1. Then drain -> 8 words in order.
- **Host burst and cap**: `dn_valid` held high with 20 words, `MAX_BURST` = 16 -> `oe` rises 3 cycles after request, 16 words with `rx_enable` = 1, then RELEASE and IDLE, then a new TURN. The remaining 4 words follow.
- **Core priority**: `tx_enable` pulses in the 2nd TURN cycle -> word captured, no `oe`. A pulse in DRIVE -> `collision` = 1 and `oe` = 0 on the next cycle.
- **Clear race**: `clr_status` = 1 in the same cycle as an overflow drop -> `rx_overflow` stays 1. `clr_status` alone next cycle -> `rx_overflow` = 0.

Source files
------------

// File: rtl/hspi_host_link.sv
// Host-side endpoint of the 16-bit half-duplex HSPI pad link: buffers core words
// in an RX FIFO and drives host words back across the pins with turnaround gaps.
module hspi_host_link #(
  parameter int DW         = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int TURN_CYC   = 2,
  parameter int MAX_BURST  = 16
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          hspi_tx_enable_i,
  input  logic [DW-1:0] hspi_data_i,
  output logic [DW-1:0] hspi_data_o,
  output logic          hspi_data_oe,
  output logic          hspi_rx_enable_o,
  input  logic          dn_valid,
  input  logic [DW-1:0] dn_data,
  output logic          dn_ready,
  output logic          up_valid,
  output logic [DW-1:0] up_data,
  input  logic          up_ready,
  input  logic          clr_status,
  output logic          rx_overflow,
  output logic          collision
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, TURN, DRIVE, RELEASE} state_t;

  state_t        state, state_nxt;
  logic [2:0]    turn_cnt;
  logic [BW-1:0] burst_cnt;
  logic          burst_full;
  logic          dn_accept;
  logic          push, pop, push_ok, drop, collide;

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full;

  logic [DW-1:0] pad_data_p1;
  logic          pad_oe_p1;
  logic          vld_p1;
  logic          ovf_q, col_q;

  assign burst_full = (burst_cnt == BW'(MAX_BURST));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (dn_valid && !hspi_tx_enable_i) state_nxt = TURN;
      TURN:    if (hspi_tx_enable_i)              state_nxt = IDLE;
               else if (turn_cnt == 3'd1)         state_nxt = DRIVE;
      DRIVE:   if (hspi_tx_enable_i)              state_nxt = IDLE;
               else if (!dn_valid || burst_full)  state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Core words are sampled whenever the host is not driving; in DRIVE they are collisions.
  always_comb begin
    dn_ready  = (state == DRIVE) && !burst_full && !hspi_tx_enable_i;
    dn_accept = dn_ready && dn_valid;
    push      = hspi_tx_enable_i && (state != DRIVE);
    collide   = hspi_tx_enable_i && (state == DRIVE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      turn_cnt  <= '0;
      burst_cnt <= '0;
    end else begin
      if (state == IDLE)      turn_cnt <= 3'(TURN_CYC);
      else if (state == TURN) turn_cnt <= turn_cnt - 3'd1;
      if (state != DRIVE)     burst_cnt <= '0;
      else if (dn_accept)     burst_cnt <= burst_cnt + 1'b1;
    end
  end

  // Pad stage: everything toward the pins comes straight from flops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pad_data_p1 <= '0;
      pad_oe_p1   <= 1'b0;
      vld_p1      <= 1'b0;
    end else begin
      pad_oe_p1 <= (state_nxt == DRIVE);
      vld_p1    <= dn_accept;
      if (dn_accept) pad_data_p1 <= dn_data;
    end
  end

  assign hspi_data_o      = pad_data_p1;
  assign hspi_data_oe     = pad_oe_p1;
  assign hspi_rx_enable_o = vld_p1;

  // RX FIFO: a pop in the same cycle frees the slot for a push into a full FIFO.
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop     = up_ready && !empty;
    push_ok = push && (!full || pop);
    drop    = push && full && !pop;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= hspi_data_i;
  end

  assign up_valid = !empty;
  assign up_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // A set event beats a simultaneous clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      col_q <= 1'b0;
    end else begin
      ovf_q <= drop    | (ovf_q & ~clr_status);
      col_q <= collide | (col_q & ~clr_status);
    end
  end

  assign rx_overflow = ovf_q;
  assign collision   = col_q;

endmodule

// File: tb/tb_hspi_host_link.sv
// Bench for hspi_host_link: queue-based link model checked every cycle plus
// directed scenarios with literal expectations.
module tb_hspi_host_link;
  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int TURN  = 2;
  localparam int MAXB  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tx = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic          oe, rxen;
  logic          dv = 1'b0;
  logic [DW-1:0] dd = '0;
  logic          dn_ready;
  logic          up_valid;
  logic [DW-1:0] up_data;
  logic          ur = 1'b0;
  logic          clr = 1'b0;
  logic          ovf, col;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hspi_host_link #(.DW(DW), .FIFO_DEPTH(DEPTH), .TURN_CYC(TURN), .MAX_BURST(MAXB)) dut (
    .clock(clk), .reset_n(rst_n),
    .hspi_tx_enable_i(tx), .hspi_data_i(din),
    .hspi_data_o(dout), .hspi_data_oe(oe), .hspi_rx_enable_o(rxen),
    .dn_valid(dv), .dn_data(dd), .dn_ready(dn_ready),
    .up_valid(up_valid), .up_data(up_data), .up_ready(ur),
    .clr_status(clr), .rx_overflow(ovf), .collision(col)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Link model: FIFO as a queue, the link as "turn cycles left / driving / releasing".
  logic [DW-1:0] mq[$];
  logic          m_ovf = 1'b0, m_col = 1'b0, m_oe = 1'b0, m_rxen = 1'b0;
  logic [DW-1:0] m_dout = '0;
  int            m_turn_left = 0;
  int            m_burst = 0;
  logic          m_drv = 1'b0, m_rel = 1'b0;
  logic          s_ready, s_acc, s_push, s_pop, s_drop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 0; m_col = 0; m_oe = 0; m_rxen = 0; m_dout = '0;
      m_turn_left = 0; m_burst = 0; m_drv = 0; m_rel = 0;
    end else begin
      s_ready = m_drv && (m_burst < MAXB) && !tx;
      s_acc   = s_ready && dv;
      s_push  = tx && !m_drv;
      s_pop   = ur && (mq.size() > 0);
      s_drop  = s_push && (mq.size() == DEPTH) && !s_pop;
      m_ovf   = s_drop || (m_ovf && !clr);
      m_col   = (tx && m_drv) || (m_col && !clr);
      if (s_pop) void'(mq.pop_front());
      if (s_push && !s_drop) mq.push_back(din);
      m_rxen = s_acc;
      if (s_acc) m_dout = dd;
      if (m_rel) m_rel = 0;
      else if (m_drv) begin
        if (tx) m_drv = 0;
        else if (!dv || m_burst == MAXB) begin m_drv = 0; m_rel = 1; end
        else if (s_acc) m_burst++;
      end else if (m_turn_left > 0) begin
        if (tx) m_turn_left = 0;
        else if (m_turn_left == 1) begin m_turn_left = 0; m_drv = 1; m_burst = 0; end
        else m_turn_left--;
      end else if (dv && !tx) m_turn_left = TURN;
      m_oe = m_drv;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_oe", 32'(oe), 32'(m_oe));
      chk("m_rx_enable", 32'(rxen), 32'(m_rxen));
      chk("m_data_o", 32'(dout), 32'(m_dout));
      chk("m_dn_ready", 32'(dn_ready), 32'(m_drv && (m_burst < MAXB) && !tx));
      chk("m_up_valid", 32'(up_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) chk("m_up_data", 32'(up_data), 32'(mq[0]));
      chk("m_rx_overflow", 32'(ovf), 32'(m_ovf));
      chk("m_collision", 32'(col), 32'(m_col));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  int   k, idx, nrx, first_win;
  logic acc, prev_oe;

  initial begin
    repeat (2) tick();
    chk("rst_oe", 32'(oe), 0);
    chk("rst_rx_enable", 32'(rxen), 0);
    chk("rst_data_o", 32'(dout), 0);
    chk("rst_dn_ready", 32'(dn_ready), 0);
    chk("rst_up_valid", 32'(up_valid), 0);
    chk("rst_flags", 32'({ovf, col}), 0);
    rst_n = 1'b1;
    tick();

    // RX ordering
    ur = 1; tx = 1; din = 16'h1234;
    tick(); chk("rx0", 32'(up_data), 32'h1234); chk("rx0_valid", 32'(up_valid), 1);
    din = 16'hABCD;
    tick(); chk("rx1", 32'(up_data), 32'hABCD);
    din = 16'h0001;
    tick(); chk("rx2", 32'(up_data), 32'h0001);
    tx = 0;
    tick(); chk("rx_empty", 32'(up_valid), 0);

    // Overflow and clear race
    ur = 0; tx = 1;
    for (int i = 0; i < 9; i++) begin din = DW'(16'hA000 + i); tick(); end
    chk("ovf_set", 32'(ovf), 1);
    chk("ovf_head", 32'(up_data), 32'hA000);
    din = 16'hA009; clr = 1;
    tick(); chk("clr_race", 32'(ovf), 1);
    tx = 0;
    tick(); chk("clr_alone", 32'(ovf), 0);
    clr = 0; ur = 1;
    for (int i = 0; i < 8; i++) begin
      chk("drain", 32'(up_data), 32'(16'hA000 + i));
      tick();
    end
    ur = 0;
    chk("drain_empty", 32'(up_valid), 0);

    // Host burst with cap
    dv = 1; idx = 0; dd = 16'hD000;
    k = 0;
    while (!oe && k < 10) begin tick(); k++; end
    chk("oe_rise_cycles", 32'(k), 32'(TURN + 1));
    chk("first_ready", 32'(dn_ready), 1);
    nrx = 0; first_win = -1; prev_oe = 1;
    for (int c = 0; c < 60; c++) begin
      acc = dv && dn_ready;
      tick();
      if (acc) begin
        idx++;
        if (idx < 20) dd = DW'(16'hD000 + idx);
        else dv = 0;
      end
      if (rxen) begin
        chk("burst_word", 32'(dout), 32'(16'hD000 + nrx));
        nrx++;
      end
      if (prev_oe && !oe && first_win < 0) first_win = nrx;
      prev_oe = oe;
    end
    chk("first_window_words", 32'(first_win), 32'(MAXB));
    chk("total_words", 32'(nrx), 20);
    chk("burst_end_oe", 32'(oe), 0);

    // Core priority during TURN
    dv = 1; dd = 16'h5555;
    tick(); chk("turn1_oe", 32'(oe), 0);
    tick();
    tx = 1; din = 16'hBEEF;
    tick();
    chk("turn_capture_valid", 32'(up_valid), 1);
    chk("turn_capture_data", 32'(up_data), 32'hBEEF);
    chk("turn_no_oe", 32'(oe), 0);
    tx = 0; dv = 0;
    tick(); chk("turn_after_oe", 32'(oe), 0);
    ur = 1; tick(); ur = 0;
    chk("turn_drained", 32'(up_valid), 0);

    // Collision during DRIVE
    dv = 1; dd = 16'hC0DE;
    repeat (3) tick();
    chk("col_drive_oe", 32'(oe), 1);
    chk("col_drive_ready", 32'(dn_ready), 1);
    tick();
    chk("col_word", 32'(dout), 32'hC0DE);
    chk("col_word_rxen", 32'(rxen), 1);
    tx = 1; din = 16'hDEAD;
    #1 chk("col_ready_same_cycle", 32'(dn_ready), 0);
    tick();
    chk("col_flag", 32'(col), 1);
    chk("col_oe_drop", 32'(oe), 0);
    chk("col_rxen_drop", 32'(rxen), 0);
    chk("col_not_captured", 32'(up_valid), 0);
    tx = 0; dv = 0;
    tick();
    clr = 1; tick(); clr = 0;
    chk("col_cleared", 32'(col), 0);

    // Reset asserted mid-DRIVE with a full FIFO and overflow set
    tx = 1;
    for (int i = 0; i < 9; i++) begin din = DW'(16'hB000 + i); tick(); end
    tx = 0;
    chk("pre_rst_ovf", 32'(ovf), 1);
    dv = 1; dd = 16'h1111;
    repeat (4) tick();
    chk("pre_rst_oe", 32'(oe), 1);
    chk("pre_rst_rxen", 32'(rxen), 1);
    #3 rst_n = 0;
    #1;
    chk("mid_rst_oe", 32'(oe), 0);
    chk("mid_rst_rxen", 32'(rxen), 0);
    chk("mid_rst_data_o", 32'(dout), 0);
    chk("mid_rst_dn_ready", 32'(dn_ready), 0);
    chk("mid_rst_up_valid", 32'(up_valid), 0);
    chk("mid_rst_flags", 32'({ovf, col}), 0);
    dv = 0;
    tick();
    rst_n = 1;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
